// File: rtl/serial_sort_stream_if.sv
// Stream bundle for the serial sorter: one input handshake (values to sort),
// one output handshake (sorted values with end-of-frame marker) and a busy flag.
// The master side drives values in and takes results out; the sorter is the slave.
interface serial_sort_stream_if #(
   parameter int WIDTH = 10
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             out_last;
   logic             busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/serial_sort_stream.sv
// Streaming insertion sorter. Collects DEPTH unsigned values one per input
// handshake, keeping the register array sorted as each value arrives, then
// replays the array one value per output handshake. Equal values keep their
// arrival order because a new value lands after every stored equal one.
module serial_sort_stream #(
   parameter int WIDTH   = 10,
   parameter int DEPTH   = 6,
   parameter bit DESCEND = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   serial_sort_stream_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic {LOAD, EMIT} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_s [DEPTH];
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    r_idx;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_last;
   logic             r_busy;

   logic [CW-1:0]    w_pos;
   logic [WIDTH-1:0] w_ins [DEPTH];
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic [CW-1:0]    w_idx_nx;

   // A stored value precedes the incoming one when it sorts earlier or is equal.
   function automatic logic goes_before(input logic [WIDTH-1:0] s,
                                        input logic [WIDTH-1:0] x);
      if (DESCEND) return (s >= x);
      else         return (s <= x);
   endfunction

   assign w_in_xfer  = bus.in_valid & r_in_ready;
   assign w_out_xfer = r_out_valid & bus.out_ready;
   assign w_idx_nx   = r_idx + CW'(1);

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign bus.busy      = r_busy;

   // Insertion point: how many valid entries go before the incoming value.
   always_comb begin
      w_pos = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < r_cnt) && goes_before(r_s[i], bus.in_data))
            w_pos = w_pos + CW'(1);
      end
   end

   // Array after inserting the incoming value at w_pos and shifting the tail up.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < w_pos)
            w_ins[i] = r_s[i];
         else if (CW'(i) == w_pos)
            w_ins[i] = bus.in_data;
         else if (CW'(i) <= r_cnt)
            w_ins[i] = r_s[(i == 0) ? 0 : i - 1];
         else
            w_ins[i] = r_s[i];
      end
   end

   // LOAD/EMIT controller with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= LOAD;
         r_cnt       <= '0;
         r_idx       <= '0;
         for (int i = 0; i < DEPTH; i++) r_s[i] <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_in_xfer) begin
                  for (int i = 0; i < DEPTH; i++) r_s[i] <= w_ins[i];
                  r_busy <= 1'b1;
                  if (r_cnt == CW'(DEPTH - 1)) begin
                     // Frame complete: present the first sorted value next cycle.
                     r_state     <= EMIT;
                     r_cnt       <= CW'(DEPTH);
                     r_idx       <= '0;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_ins[0];
                     r_out_last  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            EMIT: begin
               if (w_out_xfer) begin
                  if (r_out_last) begin
                     r_state     <= LOAD;
                     r_cnt       <= '0;
                     r_idx       <= '0;
                     r_in_ready  <= 1'b1;
                     r_out_valid <= 1'b0;
                     r_out_data  <= '0;
                     r_out_last  <= 1'b0;
                     r_busy      <= 1'b0;
                  end else begin
                     r_idx      <= w_idx_nx;
                     r_out_data <= r_s[w_idx_nx[IW-1:0]];
                     r_out_last <= (w_idx_nx == CW'(DEPTH - 1));
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_sort_stream.sv
// Bench for serial_sort_stream: an ascending and a descending instance, a
// reference model that sorts each completed frame (stable by arrival) into
// an expected queue, and per-scenario tasks comparing the output stream.
module tb_serial_sort_stream;
   localparam int W = 10;
   localparam int D = 6;

   typedef struct {
      logic [W-1:0] v;
      logic         last;
   } exp_t;

   typedef struct {
      logic         in_ready;
      logic         out_valid;
      logic [W-1:0] out_data;
      logic         out_last;
      logic         busy;
      int           cyc;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_n = 0;

   exp_t         exp_a[$];
   exp_t         exp_d[$];
   logic [W-1:0] fr_a[$];
   logic [W-1:0] fr_d[$];

   always #5 clk = ~clk;

   serial_sort_stream_if #(.WIDTH(W)) ifa ();
   serial_sort_stream_if #(.WIDTH(W)) ifd ();

   serial_sort_stream #(.WIDTH(W), .DEPTH(D), .DESCEND(1'b0)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa.slave));
   serial_sort_stream #(.WIDTH(W), .DEPTH(D), .DESCEND(1'b1)) dut_d (
      .clk(clk), .rst(rst), .bus(ifd.slave));

   // Reference: once a frame is complete, repeatedly pick the earliest-arrived
   // extreme value among the unused ones.
   task automatic model_push(input bit dsel, input logic [W-1:0] v);
      logic [W-1:0] fr[$];
      bit           used [D];
      int           best;
      exp_t         e;
      if (dsel) begin
         fr_d.push_back(v);
         if (fr_d.size() != D) return;
         fr = fr_d;
         fr_d.delete();
      end else begin
         fr_a.push_back(v);
         if (fr_a.size() != D) return;
         fr = fr_a;
         fr_a.delete();
      end
      for (int j = 0; j < D; j++) used[j] = 1'b0;
      for (int k = 0; k < D; k++) begin
         best = -1;
         for (int j = 0; j < D; j++) begin
            if (!used[j]) begin
               if (best < 0) best = j;
               else if (dsel ? (fr[j] > fr[best]) : (fr[j] < fr[best])) best = j;
            end
         end
         used[best] = 1'b1;
         e.v    = fr[best];
         e.last = (k == D - 1);
         if (dsel) exp_d.push_back(e);
         else      exp_a.push_back(e);
      end
   endtask

   // One clock cycle on the selected instance; the other one is held idle.
   task automatic cyc(input bit dsel, input logic iv, input logic [W-1:0] id,
                      input logic ordy, output obs_t o);
      if (dsel) begin
         ifd.in_valid = iv;   ifd.in_data = id;  ifd.out_ready = ordy;
         ifa.in_valid = 1'b0; ifa.in_data = '0;  ifa.out_ready = 1'b0;
      end else begin
         ifa.in_valid = iv;   ifa.in_data = id;  ifa.out_ready = ordy;
         ifd.in_valid = 1'b0; ifd.in_data = '0;  ifd.out_ready = 1'b0;
      end
      @(negedge clk);
      if (dsel) begin
         o.in_ready = ifd.in_ready; o.out_valid = ifd.out_valid;
         o.out_data = ifd.out_data; o.out_last  = ifd.out_last; o.busy = ifd.busy;
      end else begin
         o.in_ready = ifa.in_ready; o.out_valid = ifa.out_valid;
         o.out_data = ifa.out_data; o.out_last  = ifa.out_last; o.busy = ifa.busy;
      end
      o.cyc = cyc_n;
      if (iv && o.in_ready) model_push(dsel, id);
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
      ifd.in_valid = 1'b0; ifd.in_data = '0; ifd.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec += 10;
      if (ifa.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready_a: got %b want 1", ifa.in_ready); end
      if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_a: got %b want 0", ifa.out_valid); end
      if (ifa.out_data !== '0)    begin n_err++; $display("FAIL reset_out_data_a: got %0d want 0", ifa.out_data); end
      if (ifa.out_last !== 1'b0)  begin n_err++; $display("FAIL reset_out_last_a: got %b want 0", ifa.out_last); end
      if (ifa.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy_a: got %b want 0", ifa.busy); end
      if (ifd.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready_d: got %b want 1", ifd.in_ready); end
      if (ifd.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_d: got %b want 0", ifd.out_valid); end
      if (ifd.out_data !== '0)    begin n_err++; $display("FAIL reset_out_data_d: got %0d want 0", ifd.out_data); end
      if (ifd.out_last !== 1'b0)  begin n_err++; $display("FAIL reset_out_last_d: got %b want 0", ifd.out_last); end
      if (ifd.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy_d: got %b want 0", ifd.busy); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] v [D];
      logic [W-1:0] id;
      obs_t o;
      exp_t e;
      int   k, nout, acc_c;
      bit   done;
      v = '{10'd32, 10'd19, 10'd1, 10'd25, 10'd95, 10'd1000};
      k = 0; nout = 0; acc_c = -100; done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         if (k < D) id = v[k]; else id = '0;
         cyc(1'b0, (k < D), id, 1'b1, o);
         if (o.in_ready && k < D) begin
            k++;
            if (k == D) acc_c = o.cyc;
         end
         if (nout > 0 && nout < D) begin
            n_vec++;
            if (o.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_gap: out_valid %b after %0d outputs, want 1", o.out_valid, nout); end
         end
         if (o.out_valid) begin
            if (nout == 0) begin
               n_vec++;
               if (o.cyc !== acc_c + 1) begin n_err++; $display("FAIL basic_latency: first out_valid cycle %0d, want %0d", o.cyc, acc_c + 1); end
            end
            n_vec++;
            if (exp_a.size() == 0) begin
               n_err++; $display("FAIL basic_extra: got %0d, nothing expected", o.out_data);
            end else begin
               e = exp_a.pop_front();
               if (o.out_data !== e.v || o.out_last !== e.last) begin
                  n_err++; $display("FAIL basic_out: got %0d last %b, want %0d last %b", o.out_data, o.out_last, e.v, e.last);
               end
            end
            nout++;
            if (nout == D) done = 1'b1;
         end
      end
      n_vec++;
      if (!done || exp_a.size() != 0) begin n_err++; $display("FAIL basic_done: outputs %0d, want %0d", nout, D); end
   endtask

   task automatic test_stall();
      logic [W-1:0] v [D];
      logic [W-1:0] id, hd;
      logic         ordy, hl;
      obs_t o;
      exp_t e;
      int   k, nout;
      bit   done, hold;
      v = '{10'd50, 10'd677, 10'd190, 10'd5, 10'd412, 10'd862};
      k = 0; nout = 0; done = 1'b0; hold = 1'b0; hd = '0; hl = 1'b0;
      for (int t = 0; t < 60 && !done; t++) begin
         ordy = (t % 2 == 0);
         if (k < D) id = v[k]; else id = '0;
         cyc(1'b0, (k < D), id, ordy, o);
         if (o.in_ready && k < D) k++;
         if (hold) begin
            n_vec++;
            if (o.out_valid !== 1'b1 || o.out_data !== hd || o.out_last !== hl) begin
               n_err++; $display("FAIL stall_hold: got valid %b data %0d last %b, want valid 1 data %0d last %b", o.out_valid, o.out_data, o.out_last, hd, hl);
            end
         end
         hold = o.out_valid && !ordy;
         hd   = o.out_data;
         hl   = o.out_last;
         if (o.out_valid) begin
            n_vec++;
            if (o.busy !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b want 1", o.busy); end
         end
         if (o.out_valid && ordy) begin
            n_vec++;
            if (exp_a.size() == 0) begin
               n_err++; $display("FAIL stall_extra: got %0d, nothing expected", o.out_data);
            end else begin
               e = exp_a.pop_front();
               if (o.out_data !== e.v || o.out_last !== e.last) begin
                  n_err++; $display("FAIL stall_out: got %0d last %b, want %0d last %b", o.out_data, o.out_last, e.v, e.last);
               end
            end
            nout++;
            if (nout == D) done = 1'b1;
         end
      end
      n_vec++;
      if (!done || exp_a.size() != 0) begin n_err++; $display("FAIL stall_done: outputs %0d, want %0d", nout, D); end
   endtask

   task automatic test_ties();
      logic [W-1:0] v [D];
      logic [W-1:0] id;
      obs_t o;
      exp_t e;
      int   k, nout;
      bit   done;
      v = '{10'd7, 10'd3, 10'd7, 10'd3, 10'd1023, 10'd0};
      k = 0; nout = 0; done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         if (k < D) id = v[k]; else id = '0;
         cyc(1'b0, (k < D), id, 1'b1, o);
         if (o.in_ready && k < D) k++;
         if (o.out_valid) begin
            n_vec++;
            if (exp_a.size() == 0) begin
               n_err++; $display("FAIL ties_extra: got %0d, nothing expected", o.out_data);
            end else begin
               e = exp_a.pop_front();
               if (o.out_data !== e.v || o.out_last !== e.last) begin
                  n_err++; $display("FAIL ties_out: got %0d last %b, want %0d last %b", o.out_data, o.out_last, e.v, e.last);
               end
            end
            nout++;
            if (nout == D) done = 1'b1;
         end
      end
      n_vec++;
      if (!done || exp_a.size() != 0) begin n_err++; $display("FAIL ties_done: outputs %0d, want %0d", nout, D); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] v [D];
      logic [W-1:0] pre [3];
      logic [W-1:0] id;
      obs_t o;
      exp_t e;
      int   k, nout;
      bit   done;
      pre = '{10'd350, 10'd1000, 10'd611};
      v   = '{10'd31, 10'd210, 10'd801, 10'd2, 10'd9, 10'd4};
      k = 0;
      for (int t = 0; t < 20 && k < 3; t++) begin
         cyc(1'b0, 1'b1, pre[k], 1'b1, o);
         if (o.in_ready) k++;
      end
      rst = 1'b1;
      cyc(1'b0, 1'b0, '0, 1'b1, o);
      n_vec++;
      if (o.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", o.busy); end
      fr_a.delete();
      rst = 1'b0;
      k = 0; nout = 0; done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         if (k < D) id = v[k]; else id = '0;
         cyc(1'b0, (k < D), id, 1'b1, o);
         if (t == 0) begin
            n_vec++;
            if (o.busy !== 1'b0 || o.in_ready !== 1'b1 || o.out_valid !== 1'b0) begin
               n_err++; $display("FAIL rstmid_after: busy %b in_ready %b out_valid %b, want 0 1 0", o.busy, o.in_ready, o.out_valid);
            end
         end
         if (o.in_ready && k < D) k++;
         if (o.out_valid) begin
            n_vec++;
            if (exp_a.size() == 0) begin
               n_err++; $display("FAIL rstmid_extra: got %0d, nothing expected", o.out_data);
            end else begin
               e = exp_a.pop_front();
               if (o.out_data !== e.v || o.out_last !== e.last) begin
                  n_err++; $display("FAIL rstmid_out: got %0d last %b, want %0d last %b", o.out_data, o.out_last, e.v, e.last);
               end
            end
            nout++;
            if (nout == D) done = 1'b1;
         end
      end
      n_vec++;
      if (!done || exp_a.size() != 0) begin n_err++; $display("FAIL rstmid_done: outputs %0d, want %0d", nout, D); end
   endtask

   task automatic test_descend();
      logic [W-1:0] v [D];
      logic [W-1:0] id;
      obs_t o;
      exp_t e;
      int   k, nout;
      bit   done;
      v = '{10'd350, 10'd1000, 10'd611, 10'd31, 10'd210, 10'd801};
      k = 0; nout = 0; done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         if (k < D) id = v[k]; else id = 10'd555;
         cyc(1'b1, 1'b1, id, 1'b1, o);
         if (o.in_ready && k < D) k++;
         if (o.out_valid) begin
            n_vec += 2;
            if (o.in_ready !== 1'b0) begin n_err++; $display("FAIL desc_in_ready: got %b during output, want 0", o.in_ready); end
            if (exp_d.size() == 0) begin
               n_err++; $display("FAIL desc_extra: got %0d, nothing expected", o.out_data);
            end else begin
               e = exp_d.pop_front();
               if (o.out_data !== e.v || o.out_last !== e.last) begin
                  n_err++; $display("FAIL desc_out: got %0d last %b, want %0d last %b", o.out_data, o.out_last, e.v, e.last);
               end
            end
            nout++;
            if (nout == D) done = 1'b1;
         end
      end
      n_vec += 2;
      if (!done || exp_d.size() != 0) begin n_err++; $display("FAIL desc_done: outputs %0d, want %0d", nout, D); end
      if (fr_d.size() != 0) begin n_err++; $display("FAIL desc_accepts: %0d extra values accepted, want 0", fr_d.size()); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] v [2*D];
      logic [W-1:0] id;
      obs_t o;
      exp_t e;
      int   k, nout, last_c;
      bit   done;
      v = '{10'd500, 10'd3, 10'd77, 10'd1023, 10'd3, 10'd260,
            10'd900, 10'd4, 10'd600, 10'd88, 10'd0, 10'd1000};
      k = 0; nout = 0; last_c = -100; done = 1'b0;
      for (int t = 0; t < 80 && !done; t++) begin
         if (k < 2*D) id = v[k]; else id = '0;
         cyc(1'b0, (k < 2*D), id, 1'b1, o);
         if (o.in_ready && k < 2*D) begin
            k++;
            if (k == D + 1) begin
               n_vec++;
               if (o.cyc !== last_c + 1) begin n_err++; $display("FAIL b2b_restart: second frame accept cycle %0d, want %0d", o.cyc, last_c + 1); end
            end
         end
         if (o.out_valid) begin
            n_vec++;
            if (exp_a.size() == 0) begin
               n_err++; $display("FAIL b2b_extra: got %0d, nothing expected", o.out_data);
            end else begin
               e = exp_a.pop_front();
               if (o.out_data !== e.v || o.out_last !== e.last) begin
                  n_err++; $display("FAIL b2b_out: got %0d last %b, want %0d last %b", o.out_data, o.out_last, e.v, e.last);
               end
            end
            nout++;
            if (nout == D) last_c = o.cyc;
            if (nout == 2*D) done = 1'b1;
         end
      end
      n_vec++;
      if (!done || exp_a.size() != 0) begin n_err++; $display("FAIL b2b_done: outputs %0d, want %0d", nout, 2*D); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_ties();
      test_reset_mid();
      test_descend();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
